// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V fetch constants, fetch-entry type and helpers
// Contents: XLEN, NOP encoding, fetch_entry_t {inst, pc, fault}, ENTRY_W, is_misaligned().
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small in-order FIFO whose head entry is a register
// Ports:
//   clk, rst      clock, synchronous active-low reset (entries load RESET_VAL)
//   i_clear       empties the FIFO at the next edge (stored data is kept)
//   i_push/i_data write an entry; accepted when not full or when popping
//   i_pop         remove the head entry (ignored when empty)
//   o_data        head entry, driven straight from a flop
//   o_count/o_full/o_empty  occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem   [DEPTH];
    logic [WIDTH-1:0] w_shift [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_wr_idx;
    logic             w_push;
    logic             w_pop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_pop    = i_pop && !o_empty;
    assign w_push   = i_push && (!o_full || w_pop);
    // Entries shift towards slot 0 on a pop, so a simultaneous push lands one slot lower.
    assign w_wr_idx = r_count - CW'(w_pop);

    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_mid
            assign w_shift[g] = r_mem[g+1];
        end else begin : g_last
            assign w_shift[g] = r_mem[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == CW'(i))) begin
                    r_mem[i] <= i_data;
                end else if (w_pop) begin
                    r_mem[i] <= w_shift[i];
                end
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_data  = r_mem[0];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with bounded outstanding requests and flush
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pc, pc_en                current PC in, one advance pulse per accepted request out
//   imem_req_valid/ready     fetch request handshake, imem_addr = pc
//   imem_rsp_valid/data      in-order read data
//   flush                    discard buffered and in-flight fetches
//   inst_valid/ready         decode handshake; inst, inst_pc, inst_fault describe the head
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            flush,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);
    localparam fetch_entry_t RESET_ENTRY = '{inst: NOP, pc: RESET_PC, fault: 1'b0};

    if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
        $error("instruction_fetch: DEPTH must be 2 or 4");
    end

    logic [XLEN-1:0] w_head_addr;
    logic [CW-1:0]   w_outst;
    logic [CW-1:0]   w_buf_count;
    logic [CW-1:0]   r_drop;
    logic [CW:0]     w_occ;
    logic            w_addr_full;
    logic            w_addr_empty;
    logic            w_buf_full;
    logic            w_buf_empty;
    logic            w_accept;
    logic            w_rsp_ok;
    logic            w_keep;
    fetch_entry_t    w_rsp_entry;
    fetch_entry_t    w_head;

    // Slots are reserved for every in-flight request so a response always has a buffer entry.
    assign w_occ          = {1'b0, w_outst} + {1'b0, w_buf_count};
    assign imem_req_valid = rst && !flush && (r_drop == '0) && (w_occ < L_DEPTH);
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign pc_en          = w_accept;
    assign imem_addr      = pc;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_ok = imem_rsp_valid && !w_addr_empty;
    // Responses belonging to fetches issued before a flush are discarded.
    assign w_keep   = w_rsp_ok && (r_drop == '0) && !flush;

    assign w_rsp_entry = '{inst: imem_rsp_data, pc: w_head_addr, fault: is_misaligned(w_head_addr)};

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_push  (w_accept),
        .i_data  (pc),
        .i_pop   (w_rsp_ok),
        .o_data  (w_head_addr),
        .o_count (w_outst),
        .o_full  (w_addr_full),
        .o_empty (w_addr_empty)
    );

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (ENTRY_W),
        .RESET_VAL (RESET_ENTRY)
    ) u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_push  (w_keep),
        .i_data  (w_rsp_entry),
        .i_pop   (inst_ready),
        .o_data  (w_head),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    // After a flush every request still in flight, as seen after this edge, must be discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (flush) begin
            r_drop <= w_outst + CW'(w_accept) - CW'(w_rsp_ok);
        end else if (w_rsp_ok && (r_drop != '0)) begin
            r_drop <= r_drop - CW'(1);
        end
    end

    assign inst_valid = !w_buf_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign inst_fault = w_head.fault;

`ifndef SYNTHESIS
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> !w_addr_empty)
        else $error("instruction_fetch: imem response with no outstanding request");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_addr_full && w_accept && !w_rsp_ok) &&
        !(w_buf_full && w_keep && !(inst_ready && inst_valid)))
        else $error("instruction_fetch: fetch queue overflow");
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_en, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        flush, inst_valid, inst_ready, inst_fault;
    logic [31:0] pc, imem_addr, imem_rsp_data, inst, inst_pc;

    instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [31:0] pc; } m_entry_t;
    typedef struct { logic [31:0] addr; int due; } mem_req_t;

    logic        drv_rst, drv_flush, drv_req_ready, drv_inst_ready;
    bit          mem_hold, mem_rand;
    logic [31:0] pc_model;
    mem_req_t    mq[$];

    logic [31:0] m_addrq[$];
    m_entry_t    m_bufq[$];
    int          m_drop;
    bit          m_fresh;

    int          cyc, total, bad, base, cnt_pc_en, first_vld_cyc, first_acc_cyc;
    bit          seen_vld, seen_acc;
    logic [31:0] first_acc_addr;
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    logic        dlv_fault[$];
    logic        s_req_valid, s_pc_en, s_inst_valid, s_fault;
    logic [31:0] s_inst, s_inst_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_dlv(input string name, input int idx, input logic [31:0] exp_pc, input logic exp_fault);
        if (dlv_pc.size() <= idx) begin
            chk({name, "_count"}, dlv_pc.size(), idx + 1);
        end else begin
            chk({name, "_pc"}, dlv_pc[idx], exp_pc);
            chk({name, "_fault"}, dlv_fault[idx], exp_fault);
            chk({name, "_inst"}, dlv_inst[idx], mem_word(exp_pc));
        end
    endtask

    task automatic clear_obs();
        cnt_pc_en = 0; seen_vld = 0; seen_acc = 0; base = cyc;
        first_vld_cyc = -1; first_acc_cyc = -1; first_acc_addr = '0;
        dlv_pc.delete(); dlv_inst.delete(); dlv_fault.delete();
    endtask

    // One clock cycle: apply inputs, compare against the model, then advance model and environment.
    task automatic step();
        bit       m_req, m_acc, m_rsp;
        m_entry_t e;
        @(posedge clk);
        #1;
        rst = drv_rst; flush = drv_flush; imem_req_ready = drv_req_ready;
        inst_ready = drv_inst_ready; pc = pc_model;
        imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
        if (drv_rst && !mem_hold && mq.size() != 0 && mq[0].due <= cyc &&
            (!mem_rand || $urandom_range(0, 1) == 1)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #3;
        m_req = drv_rst && !drv_flush && (m_drop == 0) && (m_addrq.size() + m_bufq.size() < DEPTH);
        chk("req_valid", imem_req_valid, m_req);
        chk("pc_en", pc_en, m_req && drv_req_ready);
        if (m_req) chk("imem_addr", imem_addr, pc);
        chk("inst_valid", inst_valid, m_bufq.size() != 0);
        if (m_bufq.size() != 0) begin
            chk("inst", inst, m_bufq[0].data);
            chk("inst_pc", inst_pc, m_bufq[0].pc);
            chk("inst_fault", inst_fault, m_bufq[0].pc[1:0] != 2'b00);
        end else if (m_fresh) begin
            chk("rst_inst", inst, NOP);
            chk("rst_inst_pc", inst_pc, RESET_PC);
            chk("rst_fault", inst_fault, 1'b0);
        end

        s_req_valid = imem_req_valid; s_pc_en = pc_en; s_inst_valid = inst_valid;
        s_inst = inst; s_inst_pc = inst_pc; s_fault = inst_fault;
        if (pc_en === 1'b1) begin
            cnt_pc_en++;
            if (!seen_acc) begin
                seen_acc = 1; first_acc_addr = imem_addr; first_acc_cyc = cyc;
            end
        end
        if (inst_valid === 1'b1 && !seen_vld) begin
            seen_vld = 1; first_vld_cyc = cyc;
        end
        if (inst_valid === 1'b1 && drv_inst_ready) begin
            dlv_pc.push_back(inst_pc); dlv_inst.push_back(inst); dlv_fault.push_back(inst_fault);
        end

        if (!drv_rst) begin
            mq.delete();
            pc_model = RESET_PC;
        end else if (pc_en === 1'b1) begin
            mq.push_back('{imem_addr, cyc + 1 + (mem_rand ? int'($urandom_range(0, 2)) : 0)});
            pc_model = pc_model + 32'd4;
        end

        m_acc = m_req && drv_req_ready;
        m_rsp = imem_rsp_valid && (m_addrq.size() != 0);
        if (!drv_rst) begin
            m_addrq.delete(); m_bufq.delete(); m_drop = 0; m_fresh = 1;
        end else begin
            if (m_rsp) begin
                e.pc   = m_addrq.pop_front();
                e.data = imem_rsp_data;
            end
            if (m_acc) m_addrq.push_back(pc);
            if (drv_flush) begin
                m_bufq.delete();
                m_drop = m_addrq.size();
            end else begin
                if (drv_inst_ready && m_bufq.size() != 0) void'(m_bufq.pop_front());
                if (m_rsp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        m_bufq.push_back(e);
                        m_fresh = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_rst = 1'b0; drv_flush = 1'b0; drv_req_ready = 1'b1; drv_inst_ready = 1'b1;
        mem_hold = 0; mem_rand = 0;
        step();
        drv_rst = 1'b1;
        clear_obs();
    endtask

    int mark;

    initial begin
        rst = 1'b0; flush = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; pc = RESET_PC;
        drv_rst = 1'b0; drv_flush = 1'b0; drv_req_ready = 1'b1; drv_inst_ready = 1'b1;
        mem_hold = 0; mem_rand = 0; pc_model = RESET_PC;
        m_drop = 0; m_fresh = 1; cyc = 0; total = 0; bad = 0;
        clear_obs();

        // reset state, combinational request outputs held low
        step(); step();
        chk("a_req_valid", s_req_valid, 1'b0);
        chk("a_pc_en", s_pc_en, 1'b0);
        chk("a_inst_valid", s_inst_valid, 1'b0);
        chk("a_inst", s_inst, 32'h0000_0013);
        chk("a_inst_pc", s_inst_pc, 32'h0000_0000);
        chk("a_fault", s_fault, 1'b0);

        // 1-cycle memory, free-running decode: in-order stream, one fetch per pc_en
        do_reset();
        repeat (8) step();
        drv_req_ready = 1'b0;
        repeat (6) step();
        chk("b_startup", first_vld_cyc - base, 2);
        chk_dlv("b0", 0, 32'h0, 1'b0);
        chk_dlv("b1", 1, 32'h4, 1'b0);
        chk_dlv("b2", 2, 32'h8, 1'b0);
        chk("b_one_per_pc_en", dlv_pc.size(), cnt_pc_en);

        // decode stalled: only DEPTH requests go out, head holds
        do_reset();
        drv_inst_ready = 1'b0;
        repeat (6) step();
        chk("c_pc_en_count", cnt_pc_en, 2);
        chk("c_req_valid", s_req_valid, 1'b0);
        chk("c_inst_valid", s_inst_valid, 1'b1);
        chk("c_inst_pc", s_inst_pc, 32'h0);
        chk("c_inst", s_inst, mem_word(32'h0));

        // memory not ready for 3 cycles
        do_reset();
        drv_req_ready = 1'b0;
        repeat (3) step();
        chk("d_pc_en_count", cnt_pc_en, 0);
        chk("d_req_valid", s_req_valid, 1'b1);
        drv_req_ready = 1'b1;
        repeat (6) step();
        chk("d_first_acc", first_acc_cyc - base, 3);
        chk("d_first_vld", first_vld_cyc - base, 5);
        chk_dlv("d0", 0, 32'h0, 1'b0);
        chk_dlv("d1", 1, 32'h4, 1'b0);

        // flush with 8 and C in flight
        do_reset();
        pc_model = 32'h8; mem_hold = 1;
        repeat (3) step();
        chk("e_pc_en_count", cnt_pc_en, 2);
        chk("e_blocked", s_req_valid, 1'b0);
        chk("e_first_addr", first_acc_addr, 32'h8);
        drv_flush = 1'b1; pc_model = 32'h100;
        step();
        chk("e_flush_req", s_req_valid, 1'b0);
        drv_flush = 1'b0; mem_hold = 0;
        clear_obs();
        repeat (7) step();
        chk("e_resume_addr", first_acc_addr, 32'h100);
        chk("e_resume_cyc", first_acc_cyc - base, 2);
        chk("e_first_vld", first_vld_cyc - base, 4);
        chk_dlv("e0", 0, 32'h100, 1'b0);

        // misaligned fetch then aligned fetch
        do_reset();
        pc_model = 32'h102;
        step();
        pc_model = 32'h104;
        repeat (5) step();
        chk_dlv("f0", 0, 32'h102, 1'b1);
        chk_dlv("f1", 1, 32'h104, 1'b0);

        // reset with one buffered and one outstanding fetch
        do_reset();
        drv_inst_ready = 1'b0;
        step(); step();
        mem_hold = 1; drv_rst = 1'b0;
        step();
        drv_rst = 1'b1; mem_hold = 0; drv_inst_ready = 1'b1;
        clear_obs();
        step();
        chk("g_inst_valid", s_inst_valid, 1'b0);
        chk("g_inst", s_inst, 32'h0000_0013);
        chk("g_inst_pc", s_inst_pc, RESET_PC);
        repeat (4) step();
        chk("g_first_vld", first_vld_cyc - base, 2);
        chk_dlv("g0", 0, RESET_PC, 1'b0);

        // randomized traffic
        mem_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            drv_req_ready  = ($urandom_range(0, 3) != 0);
            drv_inst_ready = ($urandom_range(0, 2) != 0);
            drv_flush      = ($urandom_range(0, 39) == 0);
            drv_rst        = ($urandom_range(0, 299) != 0);
            if (drv_flush)
                pc_model = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
            else if ($urandom_range(0, 49) == 0)
                pc_model = pc_model + 32'h2;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction buffer entries and the maximum outstanding memory requests; legal values are 2 or 4.
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL be the address reported on inst_pc for the first fetch after reset.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 pc  in  32  current program counter from program_counter.
REQ-006 pc_en  out  1  advance strobe to program_counter, one pulse per accepted memory request.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts the request.
REQ-009 imem_addr  out  32  fetch address, equal to pc.
REQ-010 imem_rsp_valid  in  1  read data valid, in request order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  in  32  instruction word.
REQ-012 flush  in  1  discard all buffered and in-flight fetches.
REQ-013 inst_valid  out  1  instruction available to decode.
REQ-014 inst_ready  in  1  decode consumes the instruction.
REQ-015 inst  out  32  instruction word.
REQ-016 inst_pc  out  32  address the word was fetched from.
REQ-017 inst_fault  out  1  misaligned fetch: inst_pc[1:0] != 2'b00.

Function
REQ-018 imem_req_valid SHALL be high only when outstanding + buffered < DEPTH, flush is low, and no drop is pending.
REQ-019 Acceptance: imem_req_valid & imem_req_ready; pc_en SHALL equal that product in the same cycle, so the PC advances exactly once per accepted request.
REQ-020 On acceptance imem_addr SHALL be pushed into an address queue; outstanding SHALL increment.
REQ-021 On imem_rsp_valid the head address SHALL pop, outstanding SHALL decrement, and {data, addr} SHALL be written to the buffer unless dropped.
REQ-022 Buffer output SHALL be registered: a response in cycle n SHALL be visible on inst_valid/inst/inst_pc at cycle n+1 at the earliest.
REQ-023 Pop on inst_valid & inst_ready; with simultaneous push and pop, count SHALL remain unchanged and order SHALL be preserved.
REQ-024 inst, inst_pc and inst_fault SHALL stay stable while inst_valid & !inst_ready.
REQ-025 Misaligned fetch addresses SHALL still be requested; the memory data is passed through with inst_fault = 1.
REQ-026 Flush SHALL take effect at the clock edge: the buffer empties, drop_count loads the outstanding count, including any request accepted in that cycle and minus any response received in that cycle; inst_valid SHALL be low the cycle after.
REQ-027 While drop_count > 0, each response SHALL decrement drop_count and be discarded; requests SHALL resume the cycle after drop_count reaches 0.
REQ-028 Buffer full and outstanding = DEPTH SHALL block requests with no loss.
REQ-029 A response with outstanding = 0 is a protocol error; a simulation-only assertion SHALL fire, and the response SHALL be ignored.
REQ-030 Counters SHALL be $clog2(DEPTH)+1 bits wide and SHALL never wrap.

Reset
REQ-031 With rst low at a rising edge: buffer empty, outstanding = 0, drop_count = 0, inst_valid = 0, inst = 32'h00000013 (NOP), inst_pc = RESET_PC, inst_fault = 0.
REQ-032 Combinational outputs imem_req_valid and pc_en SHALL be 0 while rst is low.
REQ-033 Reset mid-operation SHALL discard in-flight requests without drop tracking; the memory model is reset concurrently.

Structure
REQ-034 XLEN = 32, NOP encoding 32'h00000013 and the fetch-entry struct {inst, pc, fault} SHALL live in the shared riscv_pkg package.
REQ-035 Sub-module fetch_fifo (parameterised DEPTH and width, registered output, full/empty/count) SHALL implement both the address queue and the instruction buffer.

Verification
REQ-036 Reset, 1-cycle memory, inst_ready = 1, PC 0 -> 4 -> 8 -> inst_pc = 0, 4, 8 on consecutive cycles after a 2-cycle start-up; pc_en pulses once per fetch.
REQ-037 inst_ready = 0 for 6 cycles, DEPTH = 2 -> exactly 2 requests accepted, then imem_req_valid = 0; pc_en stops after 2 pulses; outputs hold inst_pc = 0.
REQ-038 imem_req_ready low for 3 cycles -> pc_en = 0 and pc is unchanged; the first fetch completes 3 cycles later with no duplicates.
REQ-039 Flush with 2 in flight (addresses 8 and C) -> both responses dropped, inst_valid stays 0, and the next accepted address is the new pc value (e.g. 32'h00000100).
REQ-040 pc = 32'h00000102 -> inst_fault = 1 with inst_pc = 32'h00000102; the following aligned fetch has inst_fault = 0.
REQ-041 rst asserted with 1 request outstanding -> next cycle inst_valid = 0, inst = 32'h00000013; after release the first inst_pc = RESET_PC.
